nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/rca_4.sv | 23 ++
 rtl/nibble_serial_adder.sv | 115 +++++++++++
 tb/tb_nibble_serial_adder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, nibble width
// and the index-counter sizing helper.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index counter needs at least one bit even for a single-nibble build.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/rca_4.sv
// Four-bit ripple-carry adder; the only adder in the nibble-serial datapath.
module rca_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: latches an operand pair, adds one nibble per cycle
// through a single 4-bit ripple adder, then presents sum/cout/overflow.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     cout,
  output logic                     overflow
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;

  int               nib_lsb;
  logic [NIB_W-1:0] nib_a, nib_b, nib_sum;
  logic             nib_carry;

  assign nib_lsb = int'(idx_q) * NIB_W;
  assign nib_a   = a_q[nib_lsb +: NIB_W];
  assign nib_b   = b_q[nib_lsb +: NIB_W];

  rca_4 u_rca (
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_q),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          last_d  = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // After the top nibble is written, one hand-off cycle precedes DONE.
        if (last_q) begin
          state_d = ST_DONE;
        end else begin
          sum_d[nib_lsb +: NIB_W] = nib_sum;
          carry_d = nib_carry;
          last_d  = (idx_q == IDX_LAST);
          idx_d   = (idx_q == IDX_LAST) ? idx_q : idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Final carry_reg is the carry out of the top bit once DONE is reached.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign overflow  = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc);
    logic [W:0] t;
    exp_t       e;
    t   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (ma[W-1] == mb[W-1]) && (t[W-1] != ma[W-1]);
    return e;
  endfunction

  function automatic exp_t pop_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_ready_timeout in_ready=%0b required=1", in_ready);
    end
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    sb.push_back(model(ta, tb_v, tc));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    ok = out_valid;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_handshake got in_ready/out_valid=%b required=10", {in_ready, out_valid});
    end
    n_cmp++;
    if ({sum, cout, overflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b required 0", sum, cout, overflow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_carry_wrap();
    int   lat;
    bit   ok;
    exp_t e;
    send(16'hFFFF, 16'h0001, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_early_valid got %b required 0", out_valid);
    end
    wait_out(lat, ok);
    n_cmp++;
    if (!ok || lat != N + 1) begin
      n_bad++;
      $display("FAIL wrap_latency got %0d edges (valid=%0b) required %0d", lat, ok, N + 1);
    end
    e = pop_exp();
    n_cmp++;
    if ({sum, cout, overflow} !== {e.s, e.c, e.o} || {e.s, e.c, e.o} !== {16'h0000, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL wrap_result got sum=%h cout=%b ovf=%b required sum=0000 cout=1 ovf=0", sum, cout, overflow);
    end
    release_out();
  endtask

  task automatic test_overflow();
    int   lat;
    bit   ok;
    exp_t e;
    send(16'h7FFF, 16'h0001, 1'b0);
    wait_out(lat, ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || {sum, cout, overflow} !== {e.s, e.c, e.o} || e !== {16'h8000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_pos got sum=%h cout=%b ovf=%b required sum=8000 cout=0 ovf=1", sum, cout, overflow);
    end
    release_out();
    send(16'h1234, 16'h4321, 1'b1);
    wait_out(lat, ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || {sum, cout, overflow} !== {e.s, e.c, e.o} || e !== {16'h5556, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL add_cin got sum=%h cout=%b ovf=%b required sum=5556 cout=0 ovf=0", sum, cout, overflow);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int   lat;
    bit   ok;
    int   bad_cycles = 0;
    exp_t e;
    send(16'h8000, 16'h8001, 1'b0);
    wait_out(lat, ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || {sum, cout, overflow} !== {e.s, e.c, e.o}) begin
      n_bad++;
      $display("FAIL bp_result got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
               sum, cout, overflow, e.s, e.c, e.o);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({sum, cout, overflow} !== {e.s, e.c, e.o} || out_valid !== 1'b1 || in_ready !== 1'b0)
        bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL bp_hold got %0d unstable cycles required 0", bad_cycles);
    end
    release_out();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_return got out_valid/in_ready=%b required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_busy_ignore();
    int   lat;
    bit   ok;
    exp_t e;
    send(16'h0F0F, 16'h00F1, 1'b0);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_in_ready got %b required 0", in_ready);
    end
    in_valid = 1'b0;
    wait_out(lat, ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || {sum, cout, overflow} !== {e.s, e.c, e.o} || e !== {16'h1000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL busy_result got sum=%h cout=%b ovf=%b required sum=1000 cout=0 ovf=0", sum, cout, overflow);
    end
    release_out();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL busy_second_req got in_ready/out_valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_mid_reset();
    int   lat;
    bit   ok;
    int   spurious = 0;
    exp_t e;
    send(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, sum, cout, overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_state got in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, overflow);
    end
    void'(pop_exp());
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N + 3; i++) begin
      if (out_valid !== 1'b0) spurious++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (spurious != 0) begin
      n_bad++;
      $display("FAIL abort_no_result got %0d valid cycles required 0", spurious);
    end
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out(lat, ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || lat != N + 1 || {sum, cout, overflow} !== {e.s, e.c, e.o} || e !== {16'hFFFF, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL after_abort got sum=%h cout=%b ovf=%b lat=%0d required sum=ffff cout=1 ovf=0 lat=%0d",
               sum, cout, overflow, lat, N + 1);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    int   bad = 0;
    for (int i = 0; i < 100; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      lat = 0;
      while (!out_valid && lat < 40) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1; lat++;
      end
      out_ready = 1'b0;
      e = pop_exp();
      n_cmp++;
      if (!out_valid || {sum, cout, overflow} !== {e.s, e.c, e.o}) begin
        n_bad++;
        bad++;
        if (bad <= 5)
          $display("FAIL b2b_%0d got sum=%h cout=%b ovf=%b valid=%b required sum=%h cout=%b ovf=%b",
                   i, sum, cout, overflow, out_valid, e.s, e.c, e.o);
      end
      for (int d = $urandom_range(0, 2); d > 0; d--) begin
        @(posedge clk); #1;
      end
      release_out();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout sim time exceeded");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_carry_wrap();
    test_overflow();
    test_backpressure();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
